// File: rtl/gauss3x3_stream_if.sv
// Valid/ready pixel stream bus with a start-of-frame marker.
// The master drives valid/sof/data, and the slave drives ready.
interface gauss3x3_stream_if #(
   parameter int DATA_W = 8
);
   logic              valid;
   logic              ready;
   logic              sof;
   logic [DATA_W-1:0] data;

   modport master (output valid, output sof, output data, input ready);
   modport slave  (input valid, input sof, input data, output ready);
endinterface

// File: rtl/gauss3x3_stream.sv
// Streaming 3x3 Gaussian blur, kernel [1 2 1;2 4 2;1 2 1], normalised by 16.
// Two line buffers and a 3x3 shift window feed a 3-stage pipeline:
//   S1 window/tag capture, S2 registered sum + centre, S3 output register.
// One global enable stalls the whole pipeline under output backpressure.
module gauss3x3_stream #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int ROUND  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bypass,
   gauss3x3_stream_if.slave    in_bus,
   gauss3x3_stream_if.master   out_bus
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int SW = DATA_W + 4;
   localparam logic [SW-1:0] RND_ADD = (ROUND != 0) ? SW'(8) : '0;

   logic              en;
   logic              acc;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [CW-1:0]     pc;
   logic [RW-1:0]     pr;
   logic              last_col;
   logic              last_row;
   logic              emit;
   logic              first;

   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] top_in;
   logic [DATA_W-1:0] mid_in;

   logic [DATA_W-1:0] wt [3];
   logic [DATA_W-1:0] wm [3];
   logic [DATA_W-1:0] wb [3];
   logic              s1_valid;
   logic              s1_sof;

   logic [SW-1:0]     sum_c;
   logic [SW-1:0]     s2_sum;
   logic [DATA_W-1:0] s2_ctr;
   logic              s2_byp;
   logic              s2_valid;
   logic              s2_sof;

   logic [DATA_W-1:0] norm;
   logic [DATA_W-1:0] res;
   logic              out_valid_q;
   logic              out_sof_q;
   logic [DATA_W-1:0] out_data_q;

   assign en           = !out_valid_q || out_bus.ready;
   assign acc          = in_bus.valid && en;
   assign in_bus.ready = en;

   // An accepted sof forces the current pixel to (0,0), which resyncs mid-frame
   assign pc       = in_bus.sof ? '0 : col;
   assign pr       = in_bus.sof ? '0 : row;
   assign last_col = (pc == CW'(IMG_W - 1));
   assign last_row = (pr == RW'(IMG_H - 1));
   assign emit     = (pr >= RW'(2)) && (pc >= CW'(2));
   assign first    = (pr == RW'(2)) && (pc == CW'(2));

   assign top_in = lb0[pc];
   assign mid_in = lb1[pc];

   // Raster position of the next pixel to be accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (acc) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : pr + RW'(1);
         end else begin
            col <= pc + CW'(1);
            row <= pr;
         end
      end
   end

   // Line buffers: lb1 receives the current row, and its old entry ages into lb0
   always_ff @(posedge clk) begin
      if (acc) begin
         lb0[pc] <= lb1[pc];
         lb1[pc] <= in_bus.data;
      end
   end

   // S1: shift the new column into the window and tag whether it completes a centre
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            wt[i] <= '0;
            wm[i] <= '0;
            wb[i] <= '0;
         end
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
      end else if (en) begin
         s1_valid <= acc && emit;
         s1_sof   <= acc && first;
         if (acc) begin
            wt[2] <= wt[1];
            wt[1] <= wt[0];
            wt[0] <= top_in;
            wm[2] <= wm[1];
            wm[1] <= wm[0];
            wm[0] <= mid_in;
            wb[2] <= wb[1];
            wb[1] <= wb[0];
            wb[0] <= in_bus.data;
         end
      end
   end

   assign sum_c = SW'(wt[0]) + (SW'(wt[1]) << 1) + SW'(wt[2])
                + (SW'(wm[0]) << 1) + (SW'(wm[1]) << 2) + (SW'(wm[2]) << 1)
                + SW'(wb[0]) + (SW'(wb[1]) << 1) + SW'(wb[2]);

   // S2: register the weighted sum, centre pixel and the bypass choice together
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_sum   <= '0;
         s2_ctr   <= '0;
         s2_byp   <= 1'b0;
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
      end else if (en) begin
         s2_sum   <= sum_c;
         s2_ctr   <= wm[1];
         s2_byp   <= bypass;
         s2_valid <= s1_valid;
         s2_sof   <= s1_sof;
      end
   end

   // Max sum is 16*(2^DATA_W-1), so the normalised value always fits in DATA_W bits
   assign norm = DATA_W'((s2_sum + RND_ADD) >> 4);
   assign res  = s2_byp ? s2_ctr : norm;

   // S3: output register. Data and sof hold while the downstream stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_data_q  <= '0;
      end else if (en) begin
         out_valid_q <= s2_valid;
         out_sof_q   <= s2_sof;
         if (s2_valid) begin
            out_data_q <= res;
         end
      end
   end

   assign out_bus.valid = out_valid_q;
   assign out_bus.sof   = out_sof_q;
   assign out_bus.data  = out_data_q;

endmodule

// File: tb/tb_gauss3x3_stream.sv
// Directed bench for gauss3x3_stream on a 5x5 frame.
// Two instances share the stimulus: dut1 rounds, and dut0 truncates.
module tb_gauss3x3_stream;

   logic       clk;
   logic       rst_n;
   logic       bypass;
   logic       in_valid;
   logic       in_sof;
   logic [7:0] in_data;
   logic       out_ready;
   logic       rnd_on;
   logic       rnd_bit;

   int checks;
   int failures;
   int cyc;
   int q1[$];
   int q0[$];
   int e1[$];
   int e0[$];
   int lat_q[$];
   bit stall_prev;
   int prev_data;
   int prev_sof;

   int g16[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
   int g8r[9] = '{1, 1, 1, 1, 2, 1, 1, 1, 1};
   int g8t[9] = '{0, 1, 0, 1, 2, 1, 0, 1, 0};
   int rmp[9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

   gauss3x3_stream_if #(.DATA_W(8)) i1_in ();
   gauss3x3_stream_if #(.DATA_W(8)) i1_out ();
   gauss3x3_stream_if #(.DATA_W(8)) i0_in ();
   gauss3x3_stream_if #(.DATA_W(8)) i0_out ();

   assign i1_in.valid  = in_valid;
   assign i1_in.sof    = in_sof;
   assign i1_in.data   = in_data;
   assign i0_in.valid  = in_valid;
   assign i0_in.sof    = in_sof;
   assign i0_in.data   = in_data;
   assign out_ready    = rnd_on ? rnd_bit : 1'b1;
   assign i1_out.ready = out_ready;
   assign i0_out.ready = out_ready;

   gauss3x3_stream #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .ROUND(1)) dut1 (
      .clk     (clk),
      .rst     (rst_n),
      .bypass  (bypass),
      .in_bus  (i1_in.slave),
      .out_bus (i1_out.master)
   );

   gauss3x3_stream #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .ROUND(0)) dut0 (
      .clk     (clk),
      .rst     (rst_n),
      .bypass  (bypass),
      .in_bus  (i0_in.slave),
      .out_bus (i0_out.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Output capture, handshake/hold checks and latency on the negative edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (i1_out.valid && out_ready) begin
            q1.push_back(int'(i1_out.sof) * 256 + int'(i1_out.data));
            if (lat_q.size() > 0) check_val("latency", cyc - lat_q.pop_front(), 2);
         end
         if (i0_out.valid && out_ready)
            q0.push_back(int'(i0_out.sof) * 256 + int'(i0_out.data));
         check_val("in_ready", int'(i1_in.ready), int'(!(i1_out.valid && !out_ready)));
         if (stall_prev) begin
            check_val("hold_valid", int'(i1_out.valid), 1);
            check_val("hold_data", int'(i1_out.data), prev_data);
            check_val("hold_sof", int'(i1_out.sof), prev_sof);
         end
         stall_prev = i1_out.valid && !out_ready;
         prev_data  = int'(i1_out.data);
         prev_sof   = int'(i1_out.sof);
      end else begin
         stall_prev = 1'b0;
      end
   end

   function automatic int pix(input int kind, input int val, input int r, input int c);
      if (kind == 0) return val;
      if (kind == 1) return (r == 2 && c == 2) ? val : 0;
      return r * 5 + c;
   endfunction

   // Present one pixel and hold it until accepted. The task is entered and left just after a rising edge
   task automatic send_pix(input int d, input bit sof, input bit trig);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = 8'(d);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (i1_in.ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check_val("accept_timeout", 0, 1);
      if (ok && trig) lat_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_range(input int kind, input int val, input bit sof, input int n, input bit lat);
      for (int k = 0; k < n; k++) begin
         send_pix(pix(kind, val, k / 5, k % 5), sof && (k == 0),
                  lat && (k / 5 >= 2) && (k % 5 >= 2));
      end
   endtask

   task automatic push_exp(input int a1, input int a0, input bit s);
      e1.push_back(int'(s) * 256 + a1);
      e0.push_back(int'(s) * 256 + a0);
   endtask

   // Wait for the expected outputs (bounded), allow for extras, then compare both instances
   task automatic drain_cmp(input string name);
      int n;
      n = e1.size();
      for (int k = 0; k < 400 && (q1.size() < n || q0.size() < n); k++) @(negedge clk);
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
      check_val({name, "_count1"}, q1.size(), n);
      check_val({name, "_count0"}, q0.size(), e0.size());
      for (int i = 0; i < n; i++) begin
         check_val($sformatf("%s_r1[%0d]", name, i), (i < q1.size()) ? q1[i] : -1, e1[i]);
         check_val($sformatf("%s_r0[%0d]", name, i), (i < q0.size()) ? q0[i] : -1, e0[i]);
      end
      q1.delete();
      q0.delete();
      e1.delete();
      e0.delete();
      lat_q.delete();
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      stall_prev = 1'b0;
      prev_data  = 0;
      prev_sof   = 0;
      rst_n      = 1'b0;
      bypass     = 1'b0;
      in_valid   = 1'b0;
      in_sof     = 1'b0;
      in_data    = 8'd0;
      rnd_on     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", int'(i1_out.valid), 0);
      check_val("rst_out_data", int'(i1_out.data), 0);
      check_val("rst_out_sof", int'(i1_out.sof), 0);
      check_val("rst_in_ready", int'(i1_in.ready), 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Constant 255 frame, with each output checked 2 enabled edges after its trigger
      for (int i = 0; i < 9; i++) push_exp(255, 255, i == 0);
      send_range(0, 255, 1'b1, 25, 1'b1);
      drain_cmp("const");

      // Impulse 16: exact for both roundings
      for (int i = 0; i < 9; i++) push_exp(g16[i], g16[i], i == 0);
      send_range(1, 16, 1'b1, 25, 1'b1);
      drain_cmp("imp16");

      // Impulse 8: rounding and truncation differ
      for (int i = 0; i < 9; i++) push_exp(g8r[i], g8t[i], i == 0);
      send_range(1, 8, 1'b1, 25, 1'b0);
      drain_cmp("imp8");

      // Random backpressure
      rnd_on = 1'b1;
      for (int i = 0; i < 9; i++) push_exp(255, 255, i == 0);
      send_range(0, 255, 1'b1, 25, 1'b0);
      drain_cmp("bp");
      rnd_on = 1'b0;

      // Bypass on a ramp frame gives the centre pixels
      bypass = 1'b1;
      for (int i = 0; i < 9; i++) push_exp(rmp[i], rmp[i], i == 0);
      send_range(2, 0, 1'b1, 25, 1'b0);
      drain_cmp("bypass");
      bypass = 1'b0;

      // Resync: a partial frame whose (2,2) output is in flight, then a full frame
      push_exp(6, 6, 1'b1);
      for (int i = 0; i < 9; i++) push_exp(rmp[i], rmp[i], i == 0);
      send_range(2, 0, 1'b1, 13, 1'b0);
      send_range(2, 0, 1'b1, 25, 1'b0);
      drain_cmp("resync");

      // Reset in row 3 while centre (2,1)=11 is on the output
      send_range(2, 0, 1'b1, 19, 1'b0);
      @(posedge clk);
      #1;
      check_val("pre_rst_valid", int'(i1_out.valid), 1);
      check_val("pre_rst_data", int'(i1_out.data), 11);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", int'(i1_out.valid), 0);
      check_val("mid_rst_data", int'(i1_out.data), 0);
      q1.delete();
      q0.delete();
      lat_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) push_exp(rmp[i], rmp[i], i == 0);
      send_range(2, 0, 1'b0, 25, 1'b0);
      drain_cmp("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
